// File: rtl/auto_map_ram_if.sv
// Bus bundle for auto_map_ram: table loader stream and two banked read ports.
// master drives requests and stream words, slave is the RAM block.
interface auto_map_ram_if #(
  parameter int DLEN   = 32,
  parameter int HLEN   = 7,
  parameter int NBANK  = 2,
  parameter int NTABLE = 2,
  parameter int TW     = (NTABLE > 1) ? $clog2(NTABLE) : 1
);
  logic                    load_start;
  logic [TW-1:0]           load_table;
  logic                    ld_valid;
  logic                    ld_ready;
  logic [DLEN-1:0]         ld_data;
  logic                    load_done;
  logic                    busy;
  logic [NTABLE-1:0]       tbl_valid;
  logic                    rd_en_a;
  logic                    rd_en_b;
  logic [TW-1:0]           rd_table_a;
  logic [TW-1:0]           rd_table_b;
  logic [NBANK*HLEN-1:0]   rd_addr_a;
  logic [NBANK*HLEN-1:0]   rd_addr_b;
  logic [NBANK*DLEN-1:0]   do_a;
  logic [NBANK*DLEN-1:0]   do_b;
  logic                    do_valid_a;
  logic                    do_valid_b;
  logic                    do_stale_a;
  logic                    do_stale_b;

  modport master (
    output load_start, load_table, ld_valid, ld_data,
    output rd_en_a, rd_en_b, rd_table_a, rd_table_b, rd_addr_a, rd_addr_b,
    input  ld_ready, load_done, busy, tbl_valid,
    input  do_a, do_b, do_valid_a, do_valid_b, do_stale_a, do_stale_b
  );

  modport slave (
    input  load_start, load_table, ld_valid, ld_data,
    input  rd_en_a, rd_en_b, rd_table_a, rd_table_b, rd_addr_a, rd_addr_b,
    output ld_ready, load_done, busy, tbl_valid,
    output do_a, do_b, do_valid_a, do_valid_b, do_stale_a, do_stale_b
  );
endinterface

// File: rtl/auto_map_ram.sv
// Banked automorphism-table RAM: streaming table loader plus two read ports per bank.
// Define AUTO_MAP_OUTREG_EN to add an output register stage (read latency 2 instead of 1).
module auto_map_ram #(
  parameter int DLEN   = 32,
  parameter int HLEN   = 7,
  parameter int NBANK  = 2,
  parameter int NTABLE = 2,
  parameter int TW     = (NTABLE > 1) ? $clog2(NTABLE) : 1
) (
  input logic           clk,
  input logic           rst,
  auto_map_ram_if.slave bus
);

  localparam int DEPTH = 1 << HLEN;
  localparam int BW    = $clog2(NBANK);
  localparam int CW    = BW + HLEN;
  localparam int WORDS = NTABLE * DEPTH;
  localparam int TWP   = TW + 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(NBANK * DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Table indices beyond NTABLE exist only when NTABLE is not a power of two.
  function automatic logic table_ok(input logic [TW-1:0] t);
    return ({1'b0, t} < TWP'(NTABLE));
  endfunction

  function automatic logic tbl_hit(input logic [NTABLE-1:0] v, input logic [TW-1:0] t);
    logic hit_s;
    if (table_ok(t)) begin
      hit_s = v[t];
    end else begin
      hit_s = 1'b0;
    end
    return hit_s;
  endfunction

  state_t              state_r, state_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic [TW-1:0]       tbl_r, tbl_s;
  logic [NTABLE-1:0]   tbl_valid_r, tbl_valid_s;
  logic                ld_ready_r, ld_ready_s;
  logic                busy_r, busy_s;
  logic                load_done_r, load_done_s;
  logic                accept_s;
  logic [BW-1:0]       wbank_s;
  logic [TW+HLEN-1:0]  waddr_s;

  assign accept_s = bus.ld_valid & ld_ready_r;
  assign wbank_s  = cnt_r[BW-1:0];
  assign waddr_s  = {tbl_r, cnt_r[CW-1:BW]};

  // Loader next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    tbl_s       = tbl_r;
    tbl_valid_s = tbl_valid_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.load_start && table_ok(bus.load_table)) begin
          state_s                     = ST_LOAD;
          cnt_s                       = {CW{1'b0}};
          tbl_s                       = bus.load_table;
          tbl_valid_s[bus.load_table] = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          if (cnt_r == LAST_WORD) begin
            state_s            = ST_DONE;
            tbl_valid_s[tbl_r] = 1'b1;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    ld_ready_s  = (state_s == ST_LOAD);
    busy_s      = (state_s != ST_IDLE);
    load_done_s = (state_s == ST_DONE);
  end

  // Loader state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CW{1'b0}};
      tbl_r       <= {TW{1'b0}};
      tbl_valid_r <= {NTABLE{1'b0}};
      ld_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      load_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      tbl_r       <= tbl_s;
      tbl_valid_r <= tbl_valid_s;
      ld_ready_r  <= ld_ready_s;
      busy_r      <= busy_s;
      load_done_r <= load_done_s;
    end
  end

  assign bus.ld_ready  = ld_ready_r;
  assign bus.busy      = busy_r;
  assign bus.load_done = load_done_r;
  assign bus.tbl_valid = tbl_valid_r;

  logic [NBANK*DLEN-1:0] rdata_a_s, rdata_b_s;

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [DLEN-1:0] mem_r [WORDS];
    logic [DLEN-1:0] rd_a_r;
    logic [DLEN-1:0] rd_b_r;

    // Bank storage: nonblocking read and write give read-first on collisions.
    always_ff @(posedge clk) begin
      if (!rst && accept_s && (wbank_s == BW'(b))) begin
        mem_r[waddr_s] <= bus.ld_data;
      end
      if (!rst && bus.rd_en_a) begin
        rd_a_r <= mem_r[{bus.rd_table_a, bus.rd_addr_a[b*HLEN +: HLEN]}];
      end
      if (!rst && bus.rd_en_b) begin
        rd_b_r <= mem_r[{bus.rd_table_b, bus.rd_addr_b[b*HLEN +: HLEN]}];
      end
    end

    assign rdata_a_s[b*DLEN +: DLEN] = rd_a_r;
    assign rdata_b_s[b*DLEN +: DLEN] = rd_b_r;
  end

  logic vld_a_r, vld_b_r, stale_a_r, stale_b_r;

  // First read stage: validity and staleness captured at issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_a_r   <= 1'b0;
      vld_b_r   <= 1'b0;
      stale_a_r <= 1'b0;
      stale_b_r <= 1'b0;
    end else begin
      vld_a_r   <= bus.rd_en_a;
      vld_b_r   <= bus.rd_en_b;
      stale_a_r <= bus.rd_en_a & ~tbl_hit(tbl_valid_r, bus.rd_table_a);
      stale_b_r <= bus.rd_en_b & ~tbl_hit(tbl_valid_r, bus.rd_table_b);
    end
  end

`ifdef AUTO_MAP_OUTREG_EN
  logic [NBANK*DLEN-1:0] do_a_r, do_b_r;
  logic                  vld2_a_r, vld2_b_r, stale2_a_r, stale2_b_r;

  // Output data stage: only a completing read updates the held value.
  always_ff @(posedge clk) begin
    if (!rst && vld_a_r) begin
      do_a_r <= rdata_a_s;
    end
    if (!rst && vld_b_r) begin
      do_b_r <= rdata_b_s;
    end
  end

  // Output flag stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld2_a_r   <= 1'b0;
      vld2_b_r   <= 1'b0;
      stale2_a_r <= 1'b0;
      stale2_b_r <= 1'b0;
    end else begin
      vld2_a_r   <= vld_a_r;
      vld2_b_r   <= vld_b_r;
      stale2_a_r <= stale_a_r;
      stale2_b_r <= stale_b_r;
    end
  end

  assign bus.do_a       = do_a_r;
  assign bus.do_b       = do_b_r;
  assign bus.do_valid_a = vld2_a_r;
  assign bus.do_valid_b = vld2_b_r;
  assign bus.do_stale_a = stale2_a_r;
  assign bus.do_stale_b = stale2_b_r;
`else
  assign bus.do_a       = rdata_a_s;
  assign bus.do_b       = rdata_b_s;
  assign bus.do_valid_a = vld_a_r;
  assign bus.do_valid_b = vld_b_r;
  assign bus.do_stale_a = stale_a_r;
  assign bus.do_stale_b = stale_b_r;
`endif

endmodule
